// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, stall hold, redirect, halt and
// fetch accounting in front of a synchronous one-cycle-latency ROM.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic [31:0] fetch_cnt,
  output logic        align_err
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pc_d;
  logic        r_vld;
  logic [31:0] r_fetch_cnt;
  logic        r_align_err;

  logic [31:0] w_redir_tgt;
  logic        w_redir_misaligned;
  logic        w_take_redir;
  logic        w_hold;

  // Instruction fetches are word granular; the two low address bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  assign w_redir_tgt        = align_word(redirect_pc);
  assign w_redir_misaligned = (redirect_pc[1:0] != 2'b00);
  // Halt outranks redirect, which in turn outranks stall; both only act in RUN.
  assign w_take_redir = (r_state == S_RUN) && redirect && !halt;
  assign w_hold       = (r_state == S_RUN) && stall && r_vld && !redirect && !halt;

  // Pick the ROM address: redirect target, held instruction re-read, or next PC.
  always_comb begin
    imem_addr = r_pc;
    if (w_take_redir) begin
      imem_addr = w_redir_tgt;
    end else if (w_hold) begin
      imem_addr = r_pc_d;
    end
  end

  assign id_inst   = imem_rdata;
  assign id_pc     = r_pc_d;
  // A redirect in flight kills the wrong-path instruction immediately.
  assign id_valid  = r_vld && !redirect && (r_state == S_RUN);
  assign fetch_cnt = r_fetch_cnt;
  assign align_err = r_align_err;

  // Fetch state machine with PC, delayed PC, valid and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_PC;
      r_pc_d      <= RESET_PC;
      r_vld       <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      unique case (r_state)
        S_BOOT: begin
          if (halt) begin
            r_state <= S_HALT;
            r_vld   <= 1'b0;
          end else begin
            r_state <= S_RUN;
            r_pc_d  <= r_pc;
            r_pc    <= r_pc + 32'd4;
            r_vld   <= 1'b1;
          end
        end
        S_RUN: begin
          if (halt) begin
            r_state <= S_HALT;
            r_vld   <= 1'b0;
          end else if (redirect) begin
            r_pc_d <= w_redir_tgt;
            r_pc   <= w_redir_tgt + 32'd4;
            r_vld  <= 1'b1;
            if (w_redir_misaligned) begin
              r_align_err <= 1'b1;
            end
          end else if (!(stall && r_vld)) begin
            r_pc_d <= r_pc;
            r_pc   <= r_pc + 32'd4;
            r_vld  <= 1'b1;
          end
        end
        S_HALT: begin
          r_vld <= 1'b0;
        end
        default: begin
          r_state <= S_BOOT;
          r_vld   <= 1'b0;
        end
      endcase
    end
  end

  // Count instructions actually accepted by decode (live and not stalled).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= 32'd0;
    end else if (id_valid && !stall) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

endmodule
